mem_copy_dma: RTL and testbench

//  Bus initiator that copies a block of 32-bit words between data-memory addresses.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/mem_copy_dma.sv | 166 ++++++++++++++++
 tb/tb_mem_copy_dma.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Package: dma_pkg
// Shared types and address constants for the mem_copy_dma bus initiator.
//   dma_state_e : copy engine states (IDLE, READ, WRITE, DONE)
//   WORD_BYTES  : byte stride between consecutive 32-bit words
//   SW_ADDR     : memory-mapped switch input register
//   LED_ADDR    : memory-mapped LED output register
//   RAM_BASE    : base of the data RAM window
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] SW_ADDR    = 32'hC000_0000;
    localparam logic [31:0] LED_ADDR   = 32'hC000_0004;
    localparam logic [31:0] RAM_BASE   = 32'h0000_0400;

endpackage

// File: rtl/mem_copy_dma.sv
// Module: mem_copy_dma
// Bus initiator that copies a block of 32-bit words between data-memory
// addresses, one READ bus cycle and one WRITE bus cycle per word, using the
// processor's a/wd/we/rd data-memory port set. An external arbiter grants
// the bus; a bus cycle only completes in a cycle with bus_gnt=1.
//
// Optional feature macro: DMA_CHECKSUM_EN
//   defined     : adds output checksum[31:0], XOR of every word written,
//                 cleared on each accepted start
//   not defined : no checksum port or logic
//
// Ports:
//   clk       in   system clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   start     in   1-cycle request, sampled only in IDLE
//   abort     in   cancel the transfer in progress (READ/WRITE only)
//   src_addr  in   source byte address (word aligned)
//   dst_addr  in   destination byte address (word aligned)
//   len       in   number of words to copy
//   bus_req   out  bus request to the arbiter
//   bus_gnt   in   bus grant
//   mem_a     out  memory byte address
//   mem_wd    out  write data
//   mem_we    out  write enable, only in WRITE while granted
//   mem_rd    in   combinational read data for mem_a
//   busy      out  high while in READ/WRITE
//   done      out  1-cycle pulse on successful completion
//   err       out  1-cycle pulse on misaligned start, nothing transferred
//   checksum  out  (DMA_CHECKSUM_EN only) XOR of written words
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int LEN_W = 7
) (
`ifdef DMA_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    output logic             mem_we,
    input  logic [31:0]      mem_rd,
    output logic             busy,
    output logic             done,
    output logic             err
);

    dma_state_e       state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] cnt;
    logic             aligned;
    logic             write_fire;

    assign aligned    = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00);
    assign write_fire = (state == WRITE) && bus_gnt;

    // The write strobe follows the grant combinationally so that a write
    // never happens in a cycle the arbiter did not grant.
    always_comb begin
        mem_we = write_fire;
    end

    // mem_wd doubles as the single word buffer between the READ and WRITE
    // cycles; mem_a is loaded one edge ahead with the address of the next
    // bus cycle so the outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!aligned) begin
                            err <= 1'b1;
                        end else if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            src_ptr <= src_addr;
                            dst_ptr <= dst_addr;
                            cnt     <= len;
                            mem_a   <= src_addr;
                            bus_req <= 1'b1;
                            busy    <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end else if (bus_gnt) begin
                        mem_wd  <= mem_rd;
                        src_ptr <= src_ptr + WORD_BYTES;
                        mem_a   <= dst_ptr;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    // A granted write completes even when abort arrives in
                    // the same cycle, so pointer/count bookkeeping is kept.
                    if (bus_gnt) begin
                        dst_ptr <= dst_ptr + WORD_BYTES;
                        cnt     <= cnt - LEN_W'(1);
                    end
                    if (abort) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end else if (bus_gnt) begin
                        if (cnt == LEN_W'(1)) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            bus_req <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            mem_a <= src_ptr;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMA_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if ((state == IDLE) && start && aligned) begin
            checksum <= '0;
        end else if (write_fire) begin
            checksum <= checksum ^ mem_wd;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench: tb_mem_copy_dma
// Directed and randomized checks of mem_copy_dma against a word-level
// reference: a transfer of N words needs 2N granted bus cycles alternating
// source/destination addresses, and leaves dst[i] == src[i] afterwards.
module tb_mem_copy_dma;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [6:0]  len = '0;
    logic        bus_gnt = 1'b0;
    logic        bus_req, mem_we, busy, done, err;
    logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    // Environment: 4 KiB RAM, switch and LED registers.
    logic [31:0] ram [0:1023];
    logic [9:0]  sw = 10'h000;
    logic [9:0]  led;
    logic        tb_we = 1'b0;
    logic [31:0] tb_a = '0;
    logic [31:0] tb_wd = '0;

    int checks = 0;
    int errors = 0;

    mem_copy_dma #(.LEN_W(7)) dut (
`ifdef DMA_CHECKSUM_EN
        .checksum (checksum),
`endif
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_env(input logic [31:0] a);
        if (a == SW_ADDR)        return {22'b0, sw};
        else if (a == LED_ADDR)  return {22'b0, led};
        else if (a < 32'h1000)   return ram[a[11:2]];
        else                     return 32'h0;
    endfunction

    always_comb mem_rd = rd_env(mem_a);

    always @(posedge clk) begin
        logic [31:0] wa, wd;
        logic        we;
        we = tb_we | mem_we;
        wa = tb_we ? tb_a : mem_a;
        wd = tb_we ? tb_wd : mem_wd;
        if (we) begin
            if (wa == LED_ADDR)     led = wd[9:0];
            else if (wa < 32'h1000) ram[wa[11:2]] = wd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_a = a; tb_wd = d;
        tick();
        tb_we = 1'b0;
    endtask

    // mode 0: permanent grant, 1: random grant, 2: grant pattern 1,0,0,1
    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int mode);
        logic [31:0] vals [$];
        logic [31:0] xs;
        logic [3:0]  pat;
        logic        gv;
        int          g;
        int          lat;
        bit          fin;
        xs = '0; g = 0; lat = 0; fin = 1'b0; pat = 4'b1001;
        for (int i = 0; i < n; i++) begin
            vals.push_back(rd_env(s + 32'(4 * i)));
            xs ^= rd_env(s + 32'(4 * i));
        end
        src_addr = s; dst_addr = d; len = 7'(n); bus_gnt = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (g == 2 * n) begin
                chk1({name, "_done"}, done, 1'b1);
                chk1({name, "_busy_end"}, busy, 1'b0);
                chk1({name, "_req_end"}, bus_req, 1'b0);
                lat = k + 1;
                fin = 1'b1;
            end else begin
                chk1({name, "_busy"}, busy, 1'b1);
                chk1({name, "_done_early"}, done, 1'b0);
                chk1({name, "_req"}, bus_req, 1'b1);
                chk({name, "_mem_a"}, mem_a,
                    (g % 2 == 0) ? s + 32'(4 * (g / 2)) : d + 32'(4 * (g / 2)));
                if (g % 2 == 1) chk({name, "_mem_wd"}, mem_wd, vals[g / 2]);
                if (mode == 0)      gv = 1'b1;
                else if (mode == 1) gv = 1'($urandom_range(0, 1));
                else                gv = pat[k % 4];
                bus_gnt = gv;
                #1;
                chk1({name, "_mem_we"}, mem_we, gv && (g % 2 == 1));
                if (gv) g++;
                tick();
            end
        end
        chk1({name, "_finished"}, fin, 1'b1);
        if (mode == 0) chk({name, "_latency"}, lat, 2 * n + 1);
        tick();
        chk1({name, "_done_pulse"}, done, 1'b0);
        for (int i = 0; i < n; i++)
            chk({name, "_data"}, rd_env(d + 32'(4 * i)), vals[i]);
`ifdef DMA_CHECKSUM_EN
        chk({name, "_checksum"}, checksum, xs);
`endif
    endtask

    initial begin
        logic [31:0] s, d;
        int          n;

        // Reset state
        #1;
        chk1("rst_req", bus_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Aligned copy of 1,2,3,4
        for (int i = 0; i < 4; i++) poke(RAM_BASE + 32'(4 * i), 32'(i + 1));
        run_copy("copy4", RAM_BASE, 32'h480, 4, 0);
`ifdef DMA_CHECKSUM_EN
        chk("checksum_1234", checksum, 32'h4);
`endif

        // Switches to LEDs
        sw = 10'h2A5;
        run_copy("periph", SW_ADDR, LED_ADDR, 1, 0);
        chk("leds", {22'b0, led}, 32'h2A5);

        // Grant stalls
        poke(32'h500, 32'hDEAD_BEEF);
        poke(32'h504, 32'h1234_5678);
        run_copy("stall", 32'h500, 32'h580, 2, 2);

        // Misaligned source / destination
        bus_gnt = 1'b1;
        src_addr = 32'h402; dst_addr = 32'h480; len = 7'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("err_src", err, 1'b1);
        chk1("err_src_req", bus_req, 1'b0);
        chk1("err_src_busy", busy, 1'b0);
        tick();
        chk1("err_pulse", err, 1'b0);
        chk1("err_idle_req", bus_req, 1'b0);
        src_addr = 32'h400; dst_addr = 32'h481; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("err_dst", err, 1'b1);
        tick();

        // Zero length
        src_addr = 32'h400; dst_addr = 32'h480; len = 7'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("len0_done", done, 1'b1);
        chk1("len0_req", bus_req, 1'b0);
        chk1("len0_busy", busy, 1'b0);
        tick();
        chk1("len0_pulse", done, 1'b0);

        // Abort in the 3rd WRITE while granted; a mid-transfer start is ignored
        for (int i = 0; i < 8; i++) begin
            poke(32'h600 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            poke(32'h900 + 32'(4 * i), 32'h5555_5555);
        end
        bus_gnt = 1'b1;
        src_addr = 32'h600; dst_addr = 32'h900; len = 7'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin src_addr = 32'h400; start = 1'b1; end
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        #1;
        chk1("abort_we", mem_we, 1'b1);
        tick();
        abort = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_req", bus_req, 1'b0);
        chk1("abort_done", done, 1'b0);
        tick();
        chk1("abort_no_done", done, 1'b0);
        for (int i = 0; i < 4; i++)
            chk("abort_data", rd_env(32'h900 + 32'(4 * i)),
                (i < 3) ? 32'hA000_0000 + 32'(i) : 32'h5555_5555);

        // Asynchronous reset during READ
        bus_gnt = 1'b0;
        src_addr = 32'h400; dst_addr = 32'h480; len = 7'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("pre_rst_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_req", bus_req, 1'b0);
        chk("arst_mem_a", mem_a, 32'h0);
        chk("arst_mem_wd", mem_wd, 32'h0);
        bus_gnt = 1'b1;
        #1;
        chk1("arst_we", mem_we, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized copies with random grant
        for (int t = 0; t < 8; t++) begin
            s = RAM_BASE + 32'(4 * $urandom_range(0, 100));
            d = 32'h800 + 32'(4 * $urandom_range(0, 100));
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) poke(s + 32'(4 * i), $urandom);
            run_copy("rand", s, d, n, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
